fifo_burst_drain: RTL and testbench
===================================

# fifo_burst_drain

Read-side drain controller that sits directly downstream of the synchronous request-mode FIFO (1-cycle read latency, occupancy count output). It watches FIFO occupancy, pulls words in bursts of `BURST_LEN` (or a shorter partial burst after an idle timeout), and presents them as a ready/valid stream with `o_first`/`o_last` framing. A 2-entry output buffer with credit-based read issue sustains one word per cycle under continuous `i_ready` and loses nothing under backpressure.

## Interface
- `DATA_WIDTH`, 16: word width.
- `FIFO_SIZE`, 8: depth of the upstream FIFO; sizes the count input.
- `BURST_LEN`, 4: full burst length, 1..`FIFO_SIZE`.
- `TIMEOUT`, 16: idle cycles before a partial burst is flushed; 0 disables partial flush.
- `COUNT_WIDTH`, `$clog2(FIFO_SIZE+1)`: derived.

- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous reset, active high.
- `i_ena`  in  1  enable; gates read issue, burst start and timeout counting.
- `o_fifo_rd_req`  out  1  read request to FIFO (combinational).
- `i_fifo_data`  in  DATA_WIDTH  FIFO read data.
- `i_fifo_valid`  in  1  FIFO read data valid (one cycle after an accepted request).
- `i_fifo_count`  in  COUNT_WIDTH  FIFO occupancy.
- `o_data`  out  DATA_WIDTH  stream data (buffer head).
- `o_valid`  out  1  stream valid.
- `i_ready`  in  1  downstream ready.
- `o_first`  out  1  head word is first of its burst.
- `o_last`  out  1  head word is last of its burst.
- `o_busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE when `i_ena` and `i_fifo_count >= BURST_LEN`: `burst_len = BURST_LEN`.
- IDLE -> ISSUE when `i_ena`, `TIMEOUT != 0`, `0 < i_fifo_count < BURST_LEN` and timer == `TIMEOUT-1`: `burst_len = i_fifo_count`.
- Timer: increments on enabled IDLE cycles with `0 < count < BURST_LEN`; cleared on reset, on count == 0, on count >= BURST_LEN, and on leaving IDLE; holds while `i_ena` is low.
- On entering ISSUE, `issue_left` and `beat_left` load `burst_len`.
- pop = `o_valid && i_ready`.
- `o_fifo_rd_req = i_ena && state==ISSUE && issue_left != 0 && (buf_cnt + inflight - pop) < 2`.
- Each request decrements `issue_left`. `inflight` is the request registered for one cycle.
- ISSUE -> DRAIN when the last request is issued. DRAIN -> IDLE when the pop with `o_last` occurs.
- A word with `i_fifo_valid` high is always written into the buffer tail. It is not gated by `i_ena`.
- Buffer is a 2-entry FIFO with head at `o_data`. Simultaneous push and pop are allowed. Push into a full buffer is impossible by construction; the bench asserts this.
- Each buffered word carries first/last flags computed at capture from a capture counter over `burst_len`.
  - first = capture index 0.
  - last = capture index `burst_len-1`.
  - With `burst_len`=1, both are set.
- Bursts never overlap: a new burst starts only from IDLE, after the previous `o_last` pop.
- Count arithmetic uses COUNT_WIDTH bits. `buf_cnt + inflight` never exceeds 2.

## Timing
- Reset (async assert) values:
  - state IDLE, timer 0, buffer empty.
  - `o_valid`=0, `o_data`=0, `o_first`=0, `o_last`=0, `o_busy`=0.
  - `o_fifo_rd_req`=0.
- Reset mid-burst discards buffered and in-flight words. A `i_fifo_valid` pulse in the first cycle after deassert is ignored.
- Latency:
  - Threshold met in cycle t: ISSUE in t+1, first request in t+1.
  - Data arrives in t+2; `o_valid` high in t+3.
- Throughput: 1 word/cycle with `i_ready` held high. Read issue stalls only on buffer credit.
- `o_data`/`o_first`/`o_last` are stable while `o_valid && !i_ready`.
- `i_ena` low mid-burst: requests stop the same cycle. In-flight data is still captured and output continues. Issue resumes on the cycle `i_ena` returns high.

## Test plan
- BURST_LEN=4, FIFO preloaded 0x10..0x13, `i_ready`=1.
  - Required: 4 consecutive `o_fifo_rd_req` cycles.
  - Beats 0x10..0x13 on consecutive cycles, `o_first` on 0x10, `o_last` on 0x13.
  - `o_busy` falls the cycle after the last pop.
- Same 4 words, `i_ready` toggled 1,0,0,1,0,1...
  - Required: output exactly 0x10..0x13 in order, no duplicates.
  - Buffer-overflow assertion never fires.
  - Data held stable while stalled.
- TIMEOUT=5, 2 words (0xA0, 0xA1) written at cycle 0.
  - Required: no request for 5 cycles, then a partial burst of 2.
  - `o_first` on 0xA0, `o_last` on 0xA1.
- 9 words 0..8 preloaded, TIMEOUT=5.
  - Required: bursts {0..3} and {4..7} back-to-back with correct framing.
  - Then word 8 alone, with `o_first`=`o_last`=1, after timeout.
- `i_ena` dropped for 3 cycles after the 2nd request of a 4-word burst.
  - Required: no requests during the drop; the 2 in-flight/buffered words still emitted.
  - Remaining 2 words issued after `i_ena` returns, with correct `o_last`.
- `i_rst` asserted asynchronously mid-burst.
  - Required: `o_valid`/`o_busy`/`o_fifo_rd_req` go to 0 without waiting for a clock edge.
  - After release with FIFO refilled to 4, a fresh burst with `o_first` on its first word.

Source files
------------

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: read-side drain controller for a request-mode FIFO.
// Watches occupancy, issues bursts of reads (full or timed-out partial) and
// re-times the returned words into a framed ready/valid stream through a
// 2-entry buffer with credit-limited read issue.
module fifo_burst_drain #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_SIZE   = 8,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT     = 16,
  parameter int COUNT_WIDTH = $clog2(FIFO_SIZE + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ena,
  output logic                   o_fifo_rd_req,
  input  logic [DATA_WIDTH-1:0]  i_fifo_data,
  input  logic                   i_fifo_valid,
  input  logic [COUNT_WIDTH-1:0] i_fifo_count,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_first,
  output logic                   o_last,
  output logic                   o_busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]          T_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0]          T_ONE   = TW'(1);
  localparam logic [COUNT_WIDTH-1:0] C_BURST = COUNT_WIDTH'(BURST_LEN);
  localparam logic [COUNT_WIDTH-1:0] C_ONE   = COUNT_WIDTH'(1);
  localparam bit                     TO_EN   = (TIMEOUT != 0);

  state_t                       r_state, w_state_nxt;
  logic [TW-1:0]                r_timer;
  logic [COUNT_WIDTH-1:0]       r_burst_len, r_issue_left, r_cap_idx;
  logic                         r_inflight;
  logic                         r_rst_mask;
  logic [1:0][DATA_WIDTH-1:0]   r_buf_data;
  logic [1:0]                   r_buf_first, r_buf_last;
  logic [1:0]                   r_buf_cnt;

  logic                         w_pop, w_push, w_head_valid;
  logic                         w_full_start, w_part_start, w_start;
  logic [COUNT_WIDTH-1:0]       w_start_len;
  logic [2:0]                   w_credit;
  logic                         w_rd_req;
  logic                         w_cap_first, w_cap_last;

  assign w_head_valid = (r_buf_cnt != 2'd0);
  assign w_pop        = w_head_valid && i_ready;
  // The first valid pulse after reset release belongs to a read issued before reset.
  assign w_push       = i_fifo_valid && !r_rst_mask;

  assign w_full_start = i_ena && (i_fifo_count >= C_BURST);
  assign w_part_start = i_ena && TO_EN && (i_fifo_count != '0) &&
                        (i_fifo_count < C_BURST) && (r_timer == T_LAST);
  assign w_start      = (r_state == S_IDLE) && (w_full_start || w_part_start);
  assign w_start_len  = w_full_start ? C_BURST : i_fifo_count;

  // Slots committed after this cycle: buffered + returning - leaving.
  assign w_credit = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_req = i_ena && (r_state == S_ISSUE) && (r_issue_left != '0) &&
                    (w_credit < 3'd2);

  assign w_cap_first = (r_cap_idx == '0);
  assign w_cap_last  = (r_cap_idx == r_burst_len - C_ONE);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: start from IDLE, stop issuing after the last read, return on the last pop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)                            w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_rd_req && r_issue_left == C_ONE)  w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && r_buf_last[0])             w_state_nxt = S_IDLE;
      default:                                         w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: read request and the buffer head with its framing flags
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_fifo_rd_req = w_rd_req;
    o_valid       = w_head_valid;
    o_data        = r_buf_data[0];
    o_first       = w_head_valid && r_buf_first[0];
    o_last        = w_head_valid && r_buf_last[0];
  end

  // Idle timer: counts enabled IDLE cycles while a partial burst is waiting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_timer <= '0;
    else if (r_state != S_IDLE || w_state_nxt != S_IDLE ||
             i_fifo_count == '0 || i_fifo_count >= C_BURST)
      r_timer <= '0;
    else if (i_ena && TO_EN)
      r_timer <= r_timer + T_ONE;
  end

  // Burst bookkeeping: length latch, reads left to issue, capture index
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_burst_len  <= '0;
      r_issue_left <= '0;
      r_cap_idx    <= '0;
      r_inflight   <= 1'b0;
      r_rst_mask   <= 1'b1;
    end else begin
      r_rst_mask <= 1'b0;
      r_inflight <= w_rd_req;
      if (w_start) begin
        r_burst_len  <= w_start_len;
        r_issue_left <= w_start_len;
      end else if (w_rd_req) begin
        r_issue_left <= r_issue_left - C_ONE;
      end
      if (w_start)     r_cap_idx <= '0;
      else if (w_push) r_cap_idx <= r_cap_idx + C_ONE;
    end
  end

  // Two-entry output buffer, entry 0 is the head; push and pop may coincide
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf_data  <= '0;
      r_buf_first <= '0;
      r_buf_last  <= '0;
      r_buf_cnt   <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf_data[0]  <= i_fifo_data;
            r_buf_first[0] <= w_cap_first;
            r_buf_last[0]  <= w_cap_last;
          end else begin
            r_buf_data[1]  <= i_fifo_data;
            r_buf_first[1] <= w_cap_first;
            r_buf_last[1]  <= w_cap_last;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf_data[0]  <= r_buf_data[1];
          r_buf_first[0] <= r_buf_first[1];
          r_buf_last[0]  <= r_buf_last[1];
          r_buf_cnt      <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf_data[0]  <= i_fifo_data;
            r_buf_first[0] <= w_cap_first;
            r_buf_last[0]  <= w_cap_last;
          end else begin
            r_buf_data[0]  <= r_buf_data[1];
            r_buf_first[0] <= r_buf_first[1];
            r_buf_last[0]  <= r_buf_last[1];
            r_buf_data[1]  <= i_fifo_data;
            r_buf_first[1] <= w_cap_first;
            r_buf_last[1]  <= w_cap_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: upstream FIFO model, burst-partition scoreboard,
// per-cycle occupancy/stability checks and directed cycle-exact expectations.
module tb_fifo_burst_drain;
  localparam int DW = 16, FS = 8, BL = 4, TO = 5;
  localparam int CW = $clog2(FS + 1);

  typedef struct packed { logic [DW-1:0] d; logic f; logic l; } beat_t;

  logic          clk = 1'b0, rst = 1'b0, ena = 1'b0, ready = 1'b0;
  logic          rd_req, dvalid, ofirst, olast, busy;
  logic [DW-1:0] odata;
  logic [DW-1:0] fd_model = '0;
  logic          fv_model = 1'b0, inj_v = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_valid;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] mem [0:255];
  int            rd_ptr = 0, wr_ptr = 0;
  int            cyc = 0, checks = 0, errors = 0, occ = 0;
  beat_t         exp_q[$];
  int            req_log[$], pop_log[$], busy_log[$];
  logic [DW-1:0] prev_d = '0;
  logic          prev_f = 1'b0, prev_l = 1'b0, stall_prev = 1'b0, prev_busy = 1'b0;

  assign fifo_valid = fv_model | inj_v;
  assign fifo_data  = inj_v ? 16'hDEAD : fd_model;
  assign fifo_count = CW'(wr_ptr - rd_ptr);

  fifo_burst_drain #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .o_fifo_rd_req(rd_req),
    .i_fifo_data(fifo_data), .i_fifo_valid(fifo_valid), .i_fifo_count(fifo_count),
    .o_data(odata), .o_valid(dvalid), .i_ready(ready),
    .o_first(ofirst), .o_last(olast), .o_busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Upstream FIFO: one-cycle read latency, occupancy = written - read
  always @(posedge clk) begin
    if (rd_req) check_eq("rd_not_empty", int'(rd_ptr != wr_ptr), 1);
    if (rd_req && rd_ptr != wr_ptr) begin
      fd_model <= mem[rd_ptr[7:0]];
      fv_model <= 1'b1;
      rd_ptr   <= rd_ptr + 1;
    end else begin
      fv_model <= 1'b0;
    end
  end

  // Words held between FIFO return and stream acceptance
  always @(posedge clk or posedge rst) begin
    if (rst) occ <= 0;
    else     occ <= occ + int'(fv_model) - int'(dvalid && ready);
  end

  // Every-cycle compare against the occupancy model and the beat scoreboard
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
      prev_busy  <= 1'b0;
    end else begin
      check_eq("valid_vs_occupancy", int'(dvalid), int'(occ != 0));
      check_eq("buffer_no_overflow", int'(occ <= 2), 1);
      if (!ena) check_eq("req_gated_by_ena", int'(rd_req), 0);
      if (stall_prev) begin
        check_eq("stall_hold_valid", int'(dvalid), 1);
        check_eq("stall_hold_data", int'(odata), int'(prev_d));
        check_eq("stall_hold_first", int'(ofirst), int'(prev_f));
        check_eq("stall_hold_last", int'(olast), int'(prev_l));
      end
      if (dvalid && ready) begin
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", int'(odata), -1);
        end else begin
          check_eq("beat_data", int'(odata), int'(exp_q[0].d));
          check_eq("beat_first", int'(ofirst), int'(exp_q[0].f));
          check_eq("beat_last", int'(olast), int'(exp_q[0].l));
          void'(exp_q.pop_front());
        end
      end
      if (rd_req) req_log.push_back(cyc);
      if (prev_busy && !busy) busy_log.push_back(cyc);
      prev_busy  <= busy;
      stall_prev <= dvalid && !ready;
      prev_d     <= odata;
      prev_f     <= ofirst;
      prev_l     <= olast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = base + DW'(i);
      wr_ptr++;
    end
  endtask

  // Expected stream: n queued words split into full bursts, then one partial burst
  task automatic model_bursts(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int pos, blen;
      beat_t b;
      pos  = i % BL;
      blen = (n - (i - pos) >= BL) ? BL : n - (i - pos);
      b.d  = base + DW'(i);
      b.f  = (pos == 0);
      b.l  = (pos == blen - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
    busy_log.delete();
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check_eq(nm, exp_q.size() + int'(busy), 0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    bit  pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rd_req", int'(rd_req), 0);
    check_eq("rst_valid", int'(dvalid), 0);
    check_eq("rst_data", int'(odata), 0);
    check_eq("rst_first", int'(ofirst), 0);
    check_eq("rst_last", int'(olast), 0);
    check_eq("rst_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Full burst, ready held high
    clear_logs();
    ena = 1'b1; ready = 1'b1;
    preload(16'h10, 4); model_bursts(16'h10, 4); c0 = cyc;
    wait_done(30, "t1_complete");
    check_eq("t1_req_count", req_log.size(), 4);
    check_eq("t1_req_first", req_log[0], c0 + 1);
    check_eq("t1_req_last", req_log[3], c0 + 4);
    check_eq("t1_pop_first", pop_log[0], c0 + 3);
    check_eq("t1_pop_last", pop_log[3], c0 + 6);
    check_eq("t1_busy_fall", busy_log[0], c0 + 7);

    // Same burst under toggling backpressure
    clear_logs();
    preload(16'h20, 4); model_bursts(16'h20, 4);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || busy); i++) begin
      ready = pat[i % 6];
      tick();
    end
    ready = 1'b1;
    check_eq("t2_complete", exp_q.size() + int'(busy), 0);
    tick(); tick();
    check_eq("t2_req_count", req_log.size(), 4);
    check_eq("t2_pop_count", pop_log.size(), 4);

    // Partial burst after idle timeout
    clear_logs();
    preload(16'hA0, 2); model_bursts(16'hA0, 2); c0 = cyc;
    wait_done(40, "t3_complete");
    check_eq("t3_req_count", req_log.size(), 2);
    check_eq("t3_req_first", req_log[0], c0 + 5);
    check_eq("t3_pop_first", pop_log[0], c0 + 7);
    check_eq("t3_pop_last", pop_log[1], c0 + 8);

    // Nine words: two full bursts back to back, then a single-word burst
    clear_logs();
    preload(16'h0000, 9); model_bursts(16'h0000, 9); c0 = cyc;
    wait_done(80, "t4_complete");
    check_eq("t4_req_count", req_log.size(), 9);
    check_eq("t4_b2_req", req_log[4], c0 + 8);
    check_eq("t4_b2_pop", pop_log[4], c0 + 10);
    check_eq("t4_b3_req", req_log[8], c0 + 19);
    check_eq("t4_b3_pop", pop_log[8], c0 + 21);

    // Enable dropped for three cycles after the second request
    clear_logs();
    preload(16'h30, 4); model_bursts(16'h30, 4); c0 = cyc;
    tick(); tick(); tick();
    ena = 1'b0;
    tick(); tick(); tick();
    ena = 1'b1;
    wait_done(30, "t5_complete");
    check_eq("t5_req_count", req_log.size(), 4);
    check_eq("t5_req_2", req_log[1], c0 + 2);
    check_eq("t5_req_3", req_log[2], c0 + 6);
    check_eq("t5_req_4", req_log[3], c0 + 7);
    check_eq("t5_pop_2", pop_log[1], c0 + 4);
    check_eq("t5_pop_3", pop_log[2], c0 + 8);
    check_eq("t5_pop_4", pop_log[3], c0 + 9);

    // Asynchronous reset mid-burst, then a fresh burst
    clear_logs();
    preload(16'h50, 4); model_bursts(16'h50, 4);
    tick(); tick(); tick();
    check_eq("t6_valid_pre", int'(dvalid), 1);
    check_eq("t6_req_pre", int'(rd_req), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_valid", int'(dvalid), 0);
    check_eq("t6_async_busy", int'(busy), 0);
    check_eq("t6_async_req", int'(rd_req), 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    inj_v = 1'b1;
    wr_ptr = rd_ptr;
    clear_logs();
    preload(16'h60, 4); model_bursts(16'h60, 4); c0 = cyc;
    tick();
    inj_v = 1'b0;
    wait_done(30, "t6_complete");
    check_eq("t6_req_first", req_log[0], c0 + 1);
    check_eq("t6_pop_first", pop_log[0], c0 + 3);
    check_eq("t6_pop_count", pop_log.size(), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
